// File: rtl/wb_fifo_uart_tx.sv
// wb_fifo_uart_tx: drains a byte FIFO through its Wishbone pop port and
// shifts each byte out as a UART frame (start, DW data bits LSB first,
// optional even parity, one stop bit).
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module wb_fifo_uart_tx #(
    parameter int DW          = 8,
    parameter int CLK_DIV     = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_fifo_empty,
    output logic          o_wb_pop_stb,
    output logic          o_wb_pop_cyc,
    input  logic          i_wb_pop_ack,
    input  logic [DW-1:0] i_wb_pop_data,
    output logic          o_tx,
    output logic          o_busy,
    output logic          o_byte_done
);
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DW + 1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_MAX  = CW'(DW - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT_ACK,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [TW-1:0] to_q, to_d;
    logic [DW-1:0] shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          stb_q, stb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // Next-state, counters and shift register; outputs are derived from the
    // next state so every output is a flop that lines up with its state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        to_d    = to_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!i_fifo_empty) state_d = POP;
            end
            POP: begin
                state_d = WAIT_ACK;
                to_d    = '0;
            end
            WAIT_ACK: begin
                if (i_wb_pop_ack)        state_d = LOAD;
                else if (to_q == TO_MAX) state_d = IDLE;
                else                     to_d = to_q + 1'b1;
            end
            LOAD: begin
                // Data lands the cycle after ack (registered read address + sync RAM).
                shift_d = i_wb_pop_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^i_wb_pop_data;
`endif
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            default: begin
                // Bit-timed states: advance only at the end of a bit period.
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    case (state_q)
                        START: state_d = DATA;
                        DATA: begin
                            shift_d = shift_q >> 1;
                            if (bit_q == BIT_MAX) begin
`ifdef UART_TX_PARITY_EN
                                state_d = PARITY;
`else
                                state_d = STOP;
`endif
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: state_d = STOP;
`endif
                        default: state_d = IDLE;
                    endcase
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase

        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        stb_d  = (state_d == POP);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_MAX);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            to_q    <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            to_q    <= to_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_wb_pop_stb = stb_q;
    assign o_wb_pop_cyc = stb_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_byte_done  = done_q;

endmodule

// File: tb/tb_wb_fifo_uart_tx.sv
// Bench for wb_fifo_uart_tx: a FIFO responder model feeds bytes, the
// stimulus pushes expected frames into a scoreboard and a negedge monitor
// pops and checks every frame the DUT puts on the line.
module tb_wb_fifo_uart_tx;
    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       stb, cyc, ack = 1'b0;
    logic [7:0] pop_data = 8'h00;
    logic       tx, busy, done;
    logic       drop_ack = 1'b0;
    logic       push_en = 1'b0;
    logic [7:0] push_byte = 8'h00;

    always #5 clk = ~clk;

    wb_fifo_uart_tx #(.DW(8), .CLK_DIV(CD), .ACK_TIMEOUT(4)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_fifo_empty (fifo_empty),
        .o_wb_pop_stb (stb),
        .o_wb_pop_cyc (cyc),
        .i_wb_pop_ack (ack),
        .i_wb_pop_data(pop_data),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_byte_done  (done)
    );

    typedef struct {
        logic [7:0] data;
        int         gap;    // expected idle-high cycles before start, -1 = don't care
        bit         abort;  // frame is expected to be cut by reset
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: ack one cycle after stb, data one cycle after ack.
    logic [7:0] fq[$];
    always @(posedge clk) begin
        if (push_en) fq.push_back(push_byte);
        if (ack && fq.size() > 0) pop_data <= fq.pop_front();
        ack <= stb && !drop_ack;
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor / scoreboard checker.
    bit          in_frame = 0;
    int          fcyc = 0;
    int          gap = -1;
    int          since_stb = 0;
    int          stb_cnt = 0;
    int          bad = 0;
    logic        prev_stb = 1'b0;
    logic [10:0] fbits = '0;
    exp_t        cur;

    always @(negedge clk) begin
        if (stb === 1'b1) begin
            chk("stb_not_back_to_back", prev_stb, 1'b0);
            chk("cyc_equals_stb", cyc, stb);
            stb_cnt++;
            since_stb = 0;
        end else if (since_stb < 1000) begin
            since_stb++;
        end
        prev_stb = stb;

        if (!rst_n) begin
            if (in_frame) chk("frame_abort_expected", cur.abort, 1'b1);
            in_frame = 0;
            gap = -1;
        end else begin
            if (!in_frame) begin
                if (done !== 1'b0) chk("done_outside_frame", done, 1'b0);
                if (tx === 1'b0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_frame", sb.size(), 1);
                    end else begin
                        cur = sb.pop_front();
                        in_frame = 1;
                        fcyc = 1;
                        bad = 0;
`ifdef UART_TX_PARITY_EN
                        fbits = {1'b1, ^cur.data, cur.data, 1'b0};
`else
                        fbits = {1'b1, 1'b1, cur.data, 1'b0};
`endif
                        if (cur.gap >= 0) chk("interframe_gap", gap, cur.gap);
                        chk("stb_to_start_latency", since_stb, 3);
                    end
                end else if (gap >= 0) begin
                    gap++;
                end
            end else begin
                fcyc++;
            end

            if (in_frame) begin
                if (tx !== fbits[(fcyc - 1) / CD]) bad++;
                if (busy !== 1'b1) bad++;
                if (done !== (fcyc == FL)) bad++;
                if (fcyc == FL) begin
                    chk($sformatf("frame_%02h_bits", cur.data), bad, 0);
                    chk("frame_completed_not_abort", cur.abort, 1'b0);
                    in_frame = 0;
                    gap = 0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        push_byte = b;
        push_en = 1'b1;
        @(posedge clk);
        #1 push_en = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] d, input int g, input bit ab);
        exp_t e;
        e.data = d;
        e.gap = g;
        e.abort = ab;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || in_frame || busy || !fifo_empty) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_in_time"}, (n < 2000), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n, bad_to;
        logic busy5;

        // Reset with a non-empty FIFO: outputs idle, no strobe until release.
        expect_frame(8'hA5, -1, 0);
        push(8'hA5);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stb", stb, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_stb_hold", stb, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("stb_release_cycle", stb, 1'b0);
        @(negedge clk);
        chk("stb_one_after_release", stb, 1'b1);
        @(negedge clk);
        chk("stb_single_cycle", stb, 1'b0);
        wait_drain("byte_a5");

        // Two queued bytes: back-to-back frames with a 4-cycle idle gap.
        s0 = stb_cnt;
        expect_frame(8'h00, -1, 0);
        expect_frame(8'hFF, 4, 0);
        push(8'h00);
        push(8'hFF);
        wait_drain("bytes_00_ff");
        chk("two_stb_pulses", stb_cnt - s0, 2);

        // Ack withheld: abandon after ACK_TIMEOUT, go idle, retry the pop.
        drop_ack = 1'b1;
        expect_frame(8'h81, -1, 0);
        push(8'h81);
        n = 0;
        while (stb !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_first_stb_seen", stb, 1'b1);
        n = 0;
        bad_to = 0;
        busy5 = 1'bx;
        do begin
            @(negedge clk);
            n++;
            if (tx !== 1'b1 || done !== 1'b0) bad_to++;
            if (n == 5) busy5 = busy;
        end while (stb !== 1'b1 && n < 50);
        drop_ack = 1'b0;
        chk("timeout_retry_interval", n, 6);
        chk("timeout_idle_busy", busy5, 1'b0);
        chk("timeout_line_quiet", bad_to, 0);
        wait_drain("byte_81_retry");

        // Reset during data bit 3 of 0x55: line returns high, next byte follows.
        expect_frame(8'h55, -1, 1);
        expect_frame(8'h3C, -1, 0);
        push(8'h55);
        push(8'h3C);
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_start_seen", tx, 1'b0);
        repeat (17) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_tx_high", tx, 1'b1);
        chk("abort_busy_low", busy, 1'b0);
        chk("abort_no_done", done, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain("byte_3c_after_abort");

        // 0x07: three ones, so parity (when enabled) is 1.
        expect_frame(8'h07, -1, 0);
        push(8'h07);
        wait_drain("byte_07");

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
